// File: rtl/cbus_if.sv
// cbus_if: cache bus channel; master drives creq (valid/is_write/addr/len/strobe/data), slave drives cresp (ready/last/data)
interface cbus_if;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  strobe;
    logic [31:0] data;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  modport master(output creq, input cresp);
  modport slave(input creq, output cresp);
endinterface

// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder: word-addressed RAM target for cbus bursts (ports clk, reset, bus.slave); CBUS_MEM_STALL_EN adds LFSR-driven beat stalls
module cbus_mem_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY = 2
) (
  input logic   clk,
  input logic   reset,
  cbus_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
  state_t state, state_n;
  logic [31:0] mem [MEM_WORDS];
  logic [AW-1:0] base, idx;
  logic [3:0] len, beat, lat;
  logic wr, stall, fire, last;
`ifdef CBUS_MEM_STALL_EN
  logic [15:0] lfsr;
  logic [1:0] scnt;
  always_comb stall = lfsr[0] && scnt != 2'd3;
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
      scnt <= 2'd0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      scnt <= state == BURST && stall ? scnt + 2'd1 : 2'd0;
    end
  end
`else
  always_comb stall = 1'b0;
`endif
  always_comb begin
    idx = base + AW'(beat);
    fire = state == BURST && !stall && !reset;
    last = fire && beat == len;
    state_n = state == IDLE  ? (bus.creq.valid ? (LATENCY == 0 ? BURST : WAIT) : IDLE)
            : state == WAIT  ? (lat == 4'd0 ? BURST : WAIT)
            : state == BURST ? (last ? DONE : BURST)
            : IDLE;
    bus.cresp.ready = fire;
    bus.cresp.last = last;
    bus.cresp.data = fire && !wr ? mem[idx] : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      base <= '0;
      len <= 4'd0;
      beat <= 4'd0;
      lat <= 4'd0;
      wr <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.creq.valid) begin
        base <= bus.creq.addr[AW+1:2];
        len <= bus.creq.len;
        wr <= bus.creq.is_write;
        beat <= 4'd0;
        lat <= 4'(LATENCY - 1);
      end
      if (state == WAIT) lat <= lat - 4'd1;
      if (fire) beat <= beat + 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (fire && wr)
      for (int k = 0; k < 4; k++)
        if (bus.creq.strobe[k]) mem[idx][8*k +: 8] <= bus.creq.data[8*k +: 8];
  end
endmodule

// File: tb/tb_cbus_mem_responder.sv
// tb_cbus_mem_responder: directed scoreboard bench for cbus_mem_responder
module tb_cbus_mem_responder;
`ifdef CBUS_MEM_STALL_EN
  localparam int LAT = 0;
  localparam int MAXGAP = 3;
`else
  localparam int LAT = 2;
  localparam int MAXGAP = 0;
`endif
  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  logic [31:0] model [4096];
  cbus_if bus();
  cbus_mem_responder #(.MEM_WORDS(4096), .LATENCY(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.cresp.ready) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_ready: data=%h last=%b with no beat expected", bus.cresp.data, bus.cresp.last);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.cresp.data !== e.d || bus.cresp.last !== e.l) begin
          miscompares++;
          $display("FAIL beat: got data=%h last=%b, want data=%h last=%b", bus.cresp.data, bus.cresp.last, e.d, e.l);
        end
      end
    end
  end
  task automatic finish_run();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_beats: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask
  task automatic idle_check(input string name);
    @(negedge clk);
    vectors++;
    if (bus.cresp !== '0) begin
      miscompares++;
      $display("FAIL %s: cresp=%h, want 0", name, bus.cresp);
    end
  endtask
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] n, input logic [3:0] s,
                      input logic [31:0] d0, input logic [31:0] ds, input bit push, input int abort_at);
    int beats;
    int t0;
    int tp;
    logic [11:0] ix;
    logic [31:0] d;
    beats = abort_at > 0 ? abort_at : int'(n) + 1;
    for (int b = 0; b < beats; b++) begin
      ix = a[13:2] + 12'(b);
      d = d0 + ds * 32'(b);
      if (w)
        for (int k = 0; k < 4; k++)
          if (s[k]) model[ix][8*k +: 8] = d[8*k +: 8];
      if (push) q.push_back('{d: w ? 32'h0 : model[ix], l: b == int'(n)});
    end
    @(posedge clk);
    #1;
    bus.creq = '{valid: 1'b1, is_write: w, addr: a, len: n, strobe: s, data: d0};
    t0 = cyc;
    tp = t0 + LAT;
    for (int b = 0; b < beats; b++) begin
      int k;
      k = 0;
      @(negedge clk);
      while (!bus.cresp.ready && k < 64) begin
        k++;
        @(negedge clk);
      end
      if (!bus.cresp.ready) begin
        miscompares++;
        $display("FAIL timeout: beat %0d never became ready, want ready within 64 cycles", b);
        finish_run();
      end
      vectors++;
      if (cyc - tp - 1 > MAXGAP) begin
        miscompares++;
        $display("FAIL beat_gap: beat %0d arrived after %0d idle cycles, want <= %0d", b, cyc - tp - 1, MAXGAP);
      end
      tp = cyc;
      @(posedge clk);
      #1;
      bus.creq.data = d0 + ds * 32'(b + 1);
    end
    if (abort_at > 0) begin
      reset = 1'b1;
      idle_check("abort_ready");
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.creq = '0;
      idle_check("after_abort");
    end else begin
      bus.creq.valid = 1'b0;
      idle_check("done_cycle");
    end
  endtask
  task automatic rd1(input logic [31:0] a, input logic [31:0] want);
    q.push_back('{d: want, l: 1'b1});
    xfer(1'b0, a, 4'd0, 4'h0, 32'h0, 32'h0, 1'b0, 0);
  endtask
  initial begin
    bus.creq = '0;
    repeat (3) @(posedge clk);
    idle_check("reset_cresp");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_check("idle_cresp");
    xfer(1'b1, 32'h100, 4'd0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b1, 0);
    rd1(32'h100, 32'hDEADBEEF);
    xfer(1'b1, 32'h100, 4'd0, 4'h0, 32'h0, 32'h0, 1'b1, 0);
    rd1(32'h100, 32'hDEADBEEF);
    xfer(1'b1, 32'h0, 4'd15, 4'hF, 32'h0, 32'h11111111, 1'b1, 0);
    xfer(1'b0, 32'h0, 4'd15, 4'h0, 32'h0, 32'h0, 1'b1, 0);
    rd1(32'h3C, 32'hFFFFFFFF);
    xfer(1'b1, 32'h14, 4'd0, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    xfer(1'b1, 32'h17, 4'd0, 4'h5, 32'h12345678, 32'h0, 1'b1, 0);
    rd1(32'h14, 32'hFF34FF78);
    xfer(1'b1, 32'h3FF8, 4'd3, 4'hF, 32'hA0A0A0A0, 32'h1, 1'b1, 0);
    xfer(1'b0, 32'h3FF8, 4'd3, 4'h0, 32'h0, 32'h0, 1'b1, 0);
    rd1(32'h3FFC, 32'hA0A0A0A1);
    rd1(32'h0, 32'hA0A0A0A2);
    rd1(32'h4004, 32'hA0A0A0A3);
    xfer(1'b1, 32'h0, 4'd15, 4'hF, 32'h5A5A0000, 32'h1, 1'b1, 3);
    rd1(32'h8, 32'h5A5A0002);
    rd1(32'hC, 32'h33333333);
    xfer(1'b0, 32'h0, 4'd15, 4'h0, 32'h0, 32'h0, 1'b1, 0);
    xfer(1'b0, 32'h20, 4'd7, 4'h0, 32'h0, 32'h0, 1'b1, 0);
    repeat (3) @(posedge clk);
    finish_run();
  end
endmodule

// File: doc/cbus_mem_responder.md
Name: cbus_mem_responder

Overview:
- Memory-side responder for the cache bus (cbus): the target end of the channel DCache drives through VCacheTop (`creq` out, `cresp` in).
- Accepts single-word and burst cbus requests, serves them from an internal word-addressed memory array and returns per-beat `ready`/`last`/`data`.
- Used as the behavioural main-memory model behind DCache in simulation, and as a synthesizable on-chip RAM target.

Parameters:
- MEM_WORDS, 4096: memory depth in 32-bit words; power of two.
- LATENCY, 2: idle cycles between request acceptance and the first beat; range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- creq  input  cbus_req_t  request from the initiator. Fields used:
  - valid
  - is_write
  - addr
  - len (beats-1 encoding: MLEN_1/2/4/8/16)
  - strobe[3:0]
  - data[31:0]
- cresp  output  cbus_resp_t  response to the initiator. Fields driven: ready, last, data[31:0].

Behaviour:
- Word index: idx = addr[log2(MEM_WORDS)+1:2]. addr[1:0] are ignored. Upper bits wrap modulo MEM_WORDS.
- FSM states: IDLE, WAIT, BURST, DONE.
- Reset:
  - State goes to IDLE.
  - Latched base, len, beat counter, latency counter and write flag clear.
  - cresp = all zero.
  - Memory contents are NOT reset.
- IDLE:
  - On creq.valid, latch base=idx, len=creq.len, wr=creq.is_write, beat=0.
  - LATENCY>0: latency counter = LATENCY-1, go to WAIT.
  - LATENCY=0: go to BURST.
  - cresp.ready stays 0 in IDLE.
- WAIT: counter decrements each cycle; at 0, go to BURST next cycle. cresp.ready=0.
- BURST: each cycle is one beat, with cresp.ready=1.
  - Beat address = (base + beat) mod MEM_WORDS (INCR burst; wraps across top of memory).
  - Read: cresp.data = mem[beat address], combinational from array, valid in the same cycle as ready.
  - Write:
    - On the ready cycle, byte lane k of mem[beat address] is updated from creq.data[8k+7:8k] iff creq.strobe[k]. Strobe 0000 writes nothing.
    - cresp.data = 0.
  - cresp.last = 1 iff beat == len.
  - beat increments after each beat. After last, go to DONE.
- DONE:
  - One cycle with ready=0 and last=0. The initiator must drop valid here.
  - Return to IDLE. A new request is sampled no earlier than the cycle after DONE.
- Request fields other than data and strobe are sampled only in IDLE. Changes to them mid-transaction are ignored.
- creq.valid dropping mid-transaction is a protocol violation. The responder completes the burst regardless.
- Burst latency: first ready at cycle LATENCY+1 after valid is first seen in IDLE. Total cycles from valid to last = LATENCY + len + 1.
- Reset mid-transaction:
  - Aborts the transaction; ready=0 from the next cycle.
  - Beats already written remain in memory; no further writes occur.
- Read-after-write: a read issued after the write's DONE returns the new data, with no hazard window.

Optional Feature:
- Macro: CBUS_MEM_STALL_EN.
- Defined:
  - A 16-bit Galois LFSR (seed 16'hACE1 on reset, taps 16,14,13,11) advances every cycle.
  - In BURST, when lfsr[0]==1 the beat stalls: ready=0, last=0, no write, beat holds.
  - At most 3 consecutive stalls; a 2-bit counter forces a beat on the 4th cycle.
  - Exercises DCache tolerance of non-contiguous ready.
- Undefined: no LFSR logic. Beats are back-to-back every BURST cycle.

Test Plan:
1. Reset, LATENCY=2, read len=MLEN_1 addr 0x100 with mem[0x40]=0xDEADBEEF preloaded -> ready=1 and last=1 exactly in cycle 3 after valid; data=0xDEADBEEF; ready=0 in DONE.
2. Write burst MLEN_16 at addr 0x0 with data=beat*0x11111111 and strobe=1111, then a read burst over the same range -> 16 beats with last only on beat 15; read data matches per beat.
3. Partial strobe: mem[5]=0xFFFFFFFF, write addr 0x14, data 0x12345678, strobe 0101 -> mem[5]=0xFF34FF78.
4. Wrap: MEM_WORDS=4096, read MLEN_4 at addr 0x3FF8 -> beats return mem[4094], mem[4095], mem[0], mem[1].
5. Reset asserted at beat 3 of a 16-beat write -> ready=0 the following cycle; mem[0..2] updated, mem[3..15] unchanged; next request is served normally.
6. LATENCY=0 with CBUS_MEM_STALL_EN defined, 8-beat read -> exactly 8 ready pulses with correct data; never more than 3 consecutive stall cycles; last on the 8th pulse only.
